ov5640_pwr_seq: RTL and testbench

//  Camera bring-up sequencer: drives OV5640 PWDN/RESET timing, releases the SCCB config block, then

---
 rtl/ov5640_seq_pkg.sv | 44 ++++
 rtl/ov5640_seq_timer.sv | 37 +++
 rtl/ov5640_pwr_seq.sv | 143 ++++++++++++++
 tb/tb_ov5640_pwr_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_seq_pkg.sv
// rtl/ov5640_seq_pkg.sv - state encoding, per-state output decode and 50 MHz default timing for the OV5640 sequencer
package ov5640_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWDN     = 3'd1,
        ST_RST      = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_CFG      = 3'd4,
        ST_WAIT_MEM = 3'd5,
        ST_RUN      = 3'd6,
        ST_FAULT    = 3'd7
    } seq_state_e;

    typedef struct packed {
        logic pwdn;
        logic rst_n;
        logic cfg_rst_n;
        logic init_done;
        logic fault;
    } seq_out_t;

    localparam int DEF_T_PWDN    = 300_000;
    localparam int DEF_T_RST     = 100_000;
    localparam int DEF_T_SETTLE  = 1_050_000;
    localparam int DEF_T_CFG_TO  = 50_000_000;
    localparam int DEF_CNT_W     = 26;
    localparam int DEF_MAX_RETRY = 3;

    function automatic seq_out_t seq_decode(input seq_state_e s);
        seq_out_t o;
        o.pwdn      = (s == ST_IDLE) || (s == ST_PWDN) || (s == ST_FAULT);
        o.rst_n     = (s == ST_SETTLE) || (s == ST_CFG) || (s == ST_WAIT_MEM) || (s == ST_RUN);
        o.cfg_rst_n = (s == ST_CFG) || (s == ST_WAIT_MEM) || (s == ST_RUN);
        o.init_done = (s == ST_RUN);
        o.fault     = (s == ST_FAULT);
        return o;
    endfunction

    // Decode of IDLE doubles as the reset value of every output.
    localparam seq_out_t SEQ_OUT_RESET = '{pwdn: 1'b1, rst_n: 1'b0, cfg_rst_n: 1'b0,
                                          init_done: 1'b0, fault: 1'b0};

endpackage

// File: rtl/ov5640_seq_timer.sv
// rtl/ov5640_seq_timer.sv - shared down-counter; a load of N expires on the Nth cycle after the load edge
module ov5640_seq_timer
    import ov5640_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Parks at zero when idle so expire cannot fire again without a new load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ov5640_pwr_seq.sv
// rtl/ov5640_pwr_seq.sv - OV5640 PWDN/RESET bring-up sequencer with config timeout; OV5640_SEQ_RETRY_EN adds power-cycle retries
module ov5640_pwr_seq
    import ov5640_seq_pkg::*;
#(
    parameter int T_PWDN    = DEF_T_PWDN,
    parameter int T_RST     = DEF_T_RST,
    parameter int T_SETTLE  = DEF_T_SETTLE,
    parameter int T_CFG_TO  = DEF_T_CFG_TO,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cam_en,
    input  logic       pll_locked,
    input  logic       cfg_done,
    input  logic       sdram_init_done,
    output logic       ov5640_pwdn,
    output logic       ov5640_rst_n,
    output logic       cfg_rst_n,
    output logic       sys_init_done,
    output logic       seq_fault,
    output logic [2:0] seq_state
);

    if (T_PWDN < 1 || T_RST < 1 || T_SETTLE < 1 || T_CFG_TO < 1) begin : g_bad_load
        $error("ov5640_pwr_seq: timer loads must be at least 1");
    end
    if ($clog2(T_PWDN + 1) > CNT_W || $clog2(T_RST + 1) > CNT_W ||
        $clog2(T_SETTLE + 1) > CNT_W || $clog2(T_CFG_TO + 1) > CNT_W) begin : g_bad_width
        $error("ov5640_pwr_seq: CNT_W too narrow for timing parameters");
    end
    if (MAX_RETRY < 0) begin : g_bad_retry
        $error("ov5640_pwr_seq: MAX_RETRY must not be negative");
    end

    seq_state_e       state_q;
    seq_state_e       state_d;
    seq_out_t         out_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

`ifdef OV5640_SEQ_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef OV5640_SEQ_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE:     state_d = ST_PWDN;
            ST_PWDN:     if (tmr_expire) state_d = ST_RST;
            ST_RST:      if (tmr_expire) state_d = ST_SETTLE;
            ST_SETTLE:   if (tmr_expire) state_d = ST_CFG;
            ST_CFG: begin
                if (cfg_done) begin
                    state_d = ST_WAIT_MEM;
                end else if (tmr_expire) begin
`ifdef OV5640_SEQ_RETRY_EN
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_PWDN;
                    end else begin
                        state_d = ST_FAULT;
                    end
`else
                    state_d = ST_FAULT;
`endif
                end
            end
            ST_WAIT_MEM: if (sdram_init_done) state_d = ST_RUN;
            default:     state_d = state_q;
        endcase

        // Losing enable or clock lock beats every other transition, including IDLE->PWDN.
        if (!cam_en || !pll_locked) begin
            state_d = ST_IDLE;
        end

`ifdef OV5640_SEQ_RETRY_EN
        if (state_q == ST_IDLE || state_d == ST_RUN) begin
            retry_d = '0;
        end
`endif

        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                ST_PWDN:   tmr_val = CNT_W'(T_PWDN);
                ST_RST:    tmr_val = CNT_W'(T_RST);
                ST_SETTLE: tmr_val = CNT_W'(T_SETTLE);
                ST_CFG:    tmr_val = CNT_W'(T_CFG_TO);
                default:   tmr_load = 1'b0;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= SEQ_OUT_RESET;
        end else begin
            state_q <= state_d;
            out_q   <= seq_decode(state_d);
        end
    end

`ifdef OV5640_SEQ_RETRY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    ov5640_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load_i    (tmr_load),
        .value_i   (tmr_val),
        .expire_o  (tmr_expire)
    );

    assign ov5640_pwdn   = out_q.pwdn;
    assign ov5640_rst_n  = out_q.rst_n;
    assign cfg_rst_n     = out_q.cfg_rst_n;
    assign sys_init_done = out_q.init_done;
    assign seq_fault     = out_q.fault;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_ov5640_pwr_seq.sv
// tb/tb_ov5640_pwr_seq.sv - vector table, corner sequences and random stimulus against a reference model
`timescale 1ns/1ps
module tb_ov5640_pwr_seq;

    localparam int T_PWDN    = 6;
    localparam int T_RST     = 2;
    localparam int T_SETTLE  = 21;
    localparam int T_CFG_TO  = 50;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 26;
    localparam int TO_CFG    = 1 + T_PWDN + T_RST + T_SETTLE;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cam_en = 1'b0;
    logic       pll_locked = 1'b0;
    logic       cfg_done = 1'b0;
    logic       sdram_init_done = 1'b0;
    logic       ov5640_pwdn;
    logic       ov5640_rst_n;
    logic       cfg_rst_n;
    logic       sys_init_done;
    logic       seq_fault;
    logic [2:0] seq_state;
    logic [7:0] dut_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_st = 0;
    int m_age = 0;
    int m_retry = 0;
    int cfg_left = 0;
    int sd_left = 0;

    typedef struct {
        logic       en;
        logic       pll;
        logic       cfg;
        logic       sd;
        int         n;
        logic [2:0] st;
        logic [4:0] outs;
    } vec_t;
    vec_t tbl[13];

    ov5640_pwr_seq #(
        .T_PWDN    (T_PWDN),
        .T_RST     (T_RST),
        .T_SETTLE  (T_SETTLE),
        .T_CFG_TO  (T_CFG_TO),
        .CNT_W     (CNT_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .cam_en          (cam_en),
        .pll_locked      (pll_locked),
        .cfg_done        (cfg_done),
        .sdram_init_done (sdram_init_done),
        .ov5640_pwdn     (ov5640_pwdn),
        .ov5640_rst_n    (ov5640_rst_n),
        .cfg_rst_n       (cfg_rst_n),
        .sys_init_done   (sys_init_done),
        .seq_fault       (seq_fault),
        .seq_state       (seq_state)
    );

    always #5 sys_clk = ~sys_clk;

    assign dut_v = {seq_state, ov5640_pwdn, ov5640_rst_n, cfg_rst_n, sys_init_done, seq_fault};

    // {pwdn, rst_n, cfg_rst_n, init_done, fault} per state
    function automatic logic [4:0] spec_outs(input int st);
        case (st)
            2:       return 5'b00000;
            3:       return 5'b01000;
            4, 5:    return 5'b01100;
            6:       return 5'b01110;
            7:       return 5'b10001;
            default: return 5'b10000;
        endcase
    endfunction

    function automatic int dur(input int st);
        case (st)
            1:       return T_PWDN;
            2:       return T_RST;
            3:       return T_SETTLE;
            default: return T_CFG_TO;
        endcase
    endfunction

    task automatic model_step();
        int nxt;
        if (!sys_rst_n) begin
            m_st = 0;
            m_age = 0;
            m_retry = 0;
            return;
        end
        nxt = m_st;
        if (!cam_en || !pll_locked) begin
            nxt = 0;
        end else begin
            case (m_st)
                0:       nxt = 1;
                1, 2, 3: if (m_age + 1 >= dur(m_st)) nxt = m_st + 1;
                4: begin
                    if (cfg_done) nxt = 5;
                    else if (m_age + 1 >= T_CFG_TO) begin
`ifdef OV5640_SEQ_RETRY_EN
                        if (m_retry < MAX_RETRY) begin
                            m_retry++;
                            nxt = 1;
                        end else begin
                            nxt = 7;
                        end
`else
                        nxt = 7;
`endif
                    end
                end
                5:       if (sdram_init_done) nxt = 6;
                default: nxt = m_st;
            endcase
        end
        if (nxt == 0 || nxt == 6) m_retry = 0;
        m_age = (nxt == m_st) ? m_age + 1 : 0;
        m_st  = nxt;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, exp);
        end
    endtask

    task automatic chk(input string name, input int st);
        check(name, dut_v, {3'(st), spec_outs(st)});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            model_step();
            @(negedge sys_clk);
            cyc++;
            check("model", dut_v, {3'(m_st), spec_outs(m_st)});
        end
    endtask

    task automatic restart();
        cam_en = 1'b0;
        tick(1);
        chk("restart_idle", 0);
        cam_en = 1'b1;
        pll_locked = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd1, 5'b10000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5,  3'd1, 5'b10000};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd2, 5'b00000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd2, 5'b00000};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd3, 5'b01000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 20, 3'd3, 5'b01000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd4, 5'b01100};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 9,  3'd4, 5'b01100};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1,  3'd5, 5'b01100};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1,  3'd6, 5'b01110};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 5,  3'd6, 5'b01110};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  3'd0, 5'b10000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd1, 5'b10000};

        repeat (2) @(negedge sys_clk);
        check("reset", dut_v, 8'b000_10000);
        cam_en = 1'b1;
        pll_locked = 1'b1;
        tick(2);
        check("reset_hold", dut_v, 8'b000_10000);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cam_en          = tbl[i].en;
            pll_locked      = tbl[i].pll;
            cfg_done        = tbl[i].cfg;
            sdram_init_done = tbl[i].sd;
            tick(tbl[i].n);
            check($sformatf("vec%0d", i), dut_v, {tbl[i].st, tbl[i].outs});
        end

        // Abort in SETTLE cycle 10, then a full restart
        restart();
        tick(1 + T_PWDN + T_RST + 9);
        chk("abort_settle", 3);
        cam_en = 1'b0;
        tick(1);
        chk("abort_idle", 0);
        cam_en = 1'b1;
        tick(1);
        chk("re_pwdn_first", 1);
        tick(T_PWDN - 1);
        chk("re_pwdn_last", 1);
        tick(1);
        chk("re_rst", 2);
        tick(T_RST);
        chk("re_settle", 3);
        tick(T_SETTLE - 1);
        chk("re_settle_last", 3);
        tick(1);
        chk("re_cfg", 4);

        // Config timeout
        cfg_done = 1'b0;
        restart();
        tick(TO_CFG);
        chk("to_cfg_entry", 4);
        tick(T_CFG_TO - 1);
        chk("to_cfg_last", 4);
        tick(1);
`ifdef OV5640_SEQ_RETRY_EN
        chk("retry1_pwdn", 1);
        tick(TO_CFG - 1);
        chk("retry1_cfg", 4);
        tick(T_CFG_TO);
        chk("retry2_pwdn", 1);
        tick(TO_CFG - 1);
        chk("retry2_cfg", 4);
        tick(T_CFG_TO);
        chk("retry_fault", 7);
        cam_en = 1'b0;
        tick(1);
        chk("retry_fault_exit", 0);
        restart();
        tick(TO_CFG + T_CFG_TO + (TO_CFG - 1) + T_CFG_TO + (TO_CFG - 1) + 5);
        chk("retry2_wait", 4);
        cfg_done = 1'b1;
        tick(1);
        chk("retry2_wait_mem", 5);
        tick(1);
        chk("retry2_run", 6);
        cfg_done = 1'b0;
`else
        chk("to_fault", 7);
        tick(20);
        chk("fault_sticky", 7);
        cfg_done = 1'b1;
        tick(3);
        chk("fault_ignores_cfg", 7);
        cam_en = 1'b0;
        tick(1);
        chk("fault_exit", 0);
        cfg_done = 1'b0;
`endif

        // cfg_done on the timeout cycle, then pll glitch in RUN
        restart();
        tick(TO_CFG + T_CFG_TO - 1);
        chk("coin_cfg_last", 4);
        cfg_done = 1'b1;
        tick(1);
        chk("coin_wait_mem", 5);
        tick(1);
        chk("coin_run", 6);
        pll_locked = 1'b0;
        tick(1);
        chk("pll_glitch_idle", 0);
        pll_locked = 1'b1;
        cfg_done = 1'b0;

        // Asynchronous reset mid-CFG
        restart();
        tick(TO_CFG + 5);
        chk("arst_cfg", 4);
        #2 sys_rst_n = 1'b0;
        #1 check("arst_immediate", dut_v, 8'b000_10000);
        tick(2);
        sys_rst_n = 1'b1;
        tick(1);
        chk("arst_restart", 1);

        // WAIT_MEM with SDRAM not ready
        sdram_init_done = 1'b0;
        restart();
        tick(TO_CFG);
        cfg_done = 1'b1;
        tick(1);
        chk("wm_entry", 5);
        tick(1000);
        chk("wm_hold", 5);
        sdram_init_done = 1'b1;
        tick(1);
        chk("wm_run", 6);

        for (int c = 0; c < 5000; c++) begin
            cam_en     = ($urandom_range(0, 249) != 0);
            pll_locked = ($urandom_range(0, 599) != 0);
            if (cfg_left == 0) begin
                cfg_done = ($urandom_range(0, 9) < 3);
                cfg_left = $urandom_range(1, 80);
            end
            cfg_left--;
            if (sd_left == 0) begin
                sdram_init_done = ($urandom_range(0, 9) < 7);
                sd_left = $urandom_range(1, 30);
            end
            sd_left--;
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
